// File: rtl/audio_pkg.sv
// Shared audio constants and types for the I2S transmit path.
// The Q15 accumulator format and the 32-slot stereo frame are defined here.
package audio_pkg;

    localparam int Q_SHIFT     = 15;
    localparam int SAMPLE_W    = 16;
    localparam int ACC_W       = 32;
    localparam int FRAME_SLOTS = 32;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    // One-entry holding register: the mono sample waiting for the next frame.
    typedef struct packed {
        logic                full;
        logic [SAMPLE_W-1:0] data;
    } hold_t;

endpackage

// File: rtl/q15_round_sat.sv
// Round-half-up a sign-extended Q15 accumulator value to a 16-bit sample,
// clamping to the signed 16-bit range and flagging when a clamp occurred.
module q15_round_sat
    import audio_pkg::*;
(
    input  logic signed [ACC_W:0]    acc,
    output logic        [SAMPLE_W-1:0] sample,
    output logic                     clamp
);

    localparam logic signed [ACC_W:0] RND =
        {{(ACC_W-Q_SHIFT+1){1'b0}}, 1'b1, {(Q_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+2){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+2){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        rounded = acc + RND;
        shifted = rounded >>> Q_SHIFT;
        clamp   = 1'b0;
        sample  = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            sample = SAT_MAX[SAMPLE_W-1:0];
            clamp  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sample = SAT_MIN[SAMPLE_W-1:0];
            clamp  = 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_stage.sv
// Mono-to-stereo I2S transmitter: rounds Q15 filter output to 16 bits,
// holds one sample and serialises it to both channels of each 32-slot frame.
module i2s_tx_stage
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             sat_pulse,
    output logic             underrun
);

    localparam int                DIV_W     = 8;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] LOAD_SLOT = '0;

    logic [DIV_W-1:0]      div_q;
    logic                  sclk_q;
    logic [SLOT_W-1:0]     slot_q;
    hold_t                 hold_q;
    logic [2*SAMPLE_W-1:0] shift_q;
    logic                  sat_q;
    logic                  und_q;

    logic [SAMPLE_W-1:0]   conv_sample;
    logic                  conv_clamp;
    logic                  div_wrap;
    logic                  sclk_fall;
    logic                  frame_load;
    logic                  accept;

    q15_round_sat u_round (
        .acc    ({in_data[ACC_W-1], in_data}),
        .sample (conv_sample),
        .clamp  (conv_clamp)
    );

    assign div_wrap   = (div_q == DIV_LAST);
    assign sclk_fall  = div_wrap && sclk_q;
    // Entering slot 1 on a falling edge starts the left MSB.
    assign frame_load = sclk_fall && (slot_q == LOAD_SLOT);
    assign accept     = in_valid && !hold_q.full;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            slot_q <= '0;
        end else begin
            div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
            if (div_wrap)
                sclk_q <= !sclk_q;
            if (sclk_fall)
                slot_q <= slot_q + SLOT_W'(1);
        end
    end

    // A load in the same cycle as an accept takes the old contents; the new
    // sample stays behind for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            if (frame_load)
                hold_q.full <= 1'b0;
            if (accept) begin
                hold_q.full <= 1'b1;
                hold_q.data <= conv_sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (frame_load) begin
            shift_q <= hold_q.full ? {hold_q.data, hold_q.data} : '0;
        end else if (sclk_fall) begin
            shift_q <= {shift_q[2*SAMPLE_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            sat_q <= accept && conv_clamp;
            und_q <= frame_load && !hold_q.full;
        end
    end

    assign in_ready  = !hold_q.full;
    assign sclk      = sclk_q;
    assign lrclk     = slot_q[SLOT_W-1];
    assign sdata     = shift_q[2*SAMPLE_W-1];
    assign sat_pulse = sat_q;
    assign underrun  = und_q;

endmodule

// File: tb/tb_i2s_tx_stage.sv
// Scoreboard bench for i2s_tx_stage: a frame-level model predicts each
// transmitted word, and a serial decoder compares what appears on the wire.
module tb_i2s_tx_stage;

    localparam int CD        = 4;
    localparam int FRAME_CYC = 64 * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, sclk, lrclk, sdata, sat_pulse, underrun;

    int checks = 0;
    int errors = 0;

    i2s_tx_stage #(.CLK_DIV(CD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .sat_pulse (sat_pulse),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] conv(input logic [31:0] d, output bit sat);
        longint v;
        v   = longint'($signed(d));
        v   = (v + 16384) >>> 15;
        sat = 1'b0;
        if (v > 32767)       begin v = 32767;  sat = 1'b1; end
        else if (v < -32768) begin v = -32768; sat = 1'b1; end
        return v[15:0];
    endfunction

    // Frame-level reference model: frame n's load happens 2*CD cycles after
    // release plus n whole frames; the word sent is whatever was held then.
    bit          m_rst = 1'b1;
    bit          m_full = 1'b0;
    logic [15:0] m_hold = '0;
    bit          exp_sat = 1'b0;
    bit          exp_und = 1'b0;
    int          t = 0;
    logic [15:0] exp_frames[$];

    always @(posedge clk) begin
        bit acc, load, s;
        logic [15:0] c;
        m_rst = rst;
        if (rst) begin
            t = 0; m_full = 0; exp_sat = 0; exp_und = 0;
            exp_frames.delete();
        end else begin
            t++;
            acc  = in_valid && !m_full;
            load = (t >= 2*CD) && (((t - 2*CD) % FRAME_CYC) == 0);
            c    = conv(in_data, s);
            exp_und = load && !m_full;
            exp_sat = acc && s;
            if (load) begin
                exp_frames.push_back(m_full ? m_hold : 16'h0000);
                m_full = 0;
            end
            if (acc) begin
                m_full = 1; m_hold = c;
            end
        end
    end

    // Per-cycle handshake and pulse checks.
    always @(negedge clk) begin
        if (m_rst)
            chk("reset_outputs", {sclk, lrclk, sdata, in_ready, sat_pulse, underrun}, 6'b000100);
        else begin
            chk("in_ready", in_ready, !m_full);
            chk("sat_pulse", sat_pulse, exp_sat);
            chk("underrun", underrun, exp_und);
        end
    end

    // Serial monitor: decode bits on sclk rising edges by slot position.
    int          mon_k = 0;
    int          gap = 0;
    int          frames_done = 0;
    bit          prev_sclk = 0;
    bit          have_rise = 0;
    logic [15:0] lw = '0, rw = '0;

    always @(negedge clk) begin
        int slot;
        logic [15:0] e;
        if (m_rst) begin
            mon_k = 0; gap = 0; prev_sclk = 0; have_rise = 0; lw = '0; rw = '0;
        end else begin
            gap++;
            if (sclk && !prev_sclk) begin
                if (have_rise) chk("sclk_period", gap, 2*CD);
                gap = 0; have_rise = 1;
                slot = mon_k % 32;
                chk("lrclk_slot", lrclk, slot >= 16);
                if (slot >= 1 && slot <= 16) lw = {lw[14:0], sdata};
                else                         rw = {rw[14:0], sdata};
                if (slot == 0 && mon_k > 0) begin
                    if (exp_frames.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_queue: got empty queue expected a pending word at %0t", $time);
                    end else begin
                        e = exp_frames.pop_front();
                        chk("left_word", lw, e);
                        chk("right_word", rw, e);
                        frames_done++;
                    end
                end
                mon_k++;
            end
            prev_sclk = sclk;
        end
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        in_data = d; in_valid = 1'b1;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no in_ready expected accept within 2000 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        while (!(mon_k > 0 && ((mon_k - 1) % 32) == s) && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL wait_slot: got timeout expected slot %0d", s);
        end
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] dir[6];
        logic signed [15:0] s16;
        time tprev;
        int n;
        s16 = 16'hA5C3;
        dir = '{32'h0000_4000, 32'hFFFF_C000, 32'hFFFF_BFFF, 32'h4000_0000,
                32'h8000_0000, {s16[15], s16, 15'b0}};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle: underrun frames of zeros, then a late sample in slot 10.
        repeat (FRAME_CYC + 100) @(negedge clk);
        wait_slot(10);
        send($urandom);

        // Directed rounding/saturation/framing vectors, then held back-pressure.
        tprev = $time;
        for (int i = 0; i < 6; i++) begin
            send(dir[i]);
            if (i >= 1) chk("accept_interval", ($time - tprev) / 10, FRAME_CYC);
            tprev = $time;
        end
        for (int i = 0; i < 5; i++) begin
            send($urandom);
            chk("bp_accept_interval", ($time - tprev) / 10, FRAME_CYC);
            tprev = $time;
        end

        // Sparse random traffic.
        repeat (1200) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 5) == 0);
            in_data  = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Reset mid-frame with a sample pending.
        wait_slot(5);
        send($urandom);
        wait_slot(20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!underrun && n < 100) begin @(negedge clk); n++; end
        chk("first_load_after_reset", n, 2*CD);

        repeat (3 * FRAME_CYC) @(negedge clk);
        chk("frames_decoded_min", frames_done >= 15, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
